// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - registered 8-bit ALU with a 16-bit tri-stateable result bus
// One operation per clock; the result register drives d_out only while oe is high.

module alu_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        oe,
  input  logic [3:0]  command_in,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic [15:0] d_out
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_INC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_NOR  = 4'd13;
  localparam logic [3:0] OP_XNOR = 4'd14;
  localparam logic [3:0] OP_BUF  = 4'd15;

  logic [15:0] w_a16;
  logic [15:0] w_b16;
  logic [15:0] w_result;
  logic [15:0] r_result;

  assign w_a16 = {8'h00, a_in};
  assign w_b16 = {8'h00, b_in};

  // Arithmetic runs at 16 bits so carries, borrows and products land in the upper byte.
  always_comb begin
    w_result = 16'h0000;
    case (command_in)
      OP_ADD:  w_result = w_a16 + w_b16;
      OP_INC:  w_result = w_a16 + 16'd1;
      OP_SUB:  w_result = w_a16 - w_b16;
      OP_DEC:  w_result = w_a16 - 16'd1;
      OP_MUL:  w_result = w_a16 * w_b16;
      OP_DIV:  w_result = (b_in == 8'h00) ? 16'hFFFF : {8'h00, a_in / b_in};
      OP_SHL:  w_result = w_a16 << 1;
      OP_SHR:  w_result = {8'h00, a_in >> 1};
      OP_AND:  w_result = {8'h00, a_in & b_in};
      OP_OR:   w_result = {8'h00, a_in | b_in};
      OP_XOR:  w_result = {8'h00, a_in ^ b_in};
      OP_NOT:  w_result = {8'h00, ~a_in};
      OP_NAND: w_result = {8'h00, ~(a_in & b_in)};
      OP_NOR:  w_result = {8'h00, ~(a_in | b_in)};
      OP_XNOR: w_result = {8'h00, ~(a_in ^ b_in)};
      OP_BUF:  w_result = w_a16;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= 16'h0000;
    end else begin
      r_result <= w_result;
    end
  end

  // Output enable only gates the bus driver; the register keeps capturing.
  assign d_out = oe ? r_result : 16'hzzzz;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - directed self-checking bench for alu_unit
// Inputs change on the falling edge; results are sampled 1 ns after the rising edge.

module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic        oe;
  logic [3:0]  command_in;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  wire  [15:0] d_out;

  int n_tests;
  int n_fail;

  alu_unit dut (
    .clk        (clk),
    .rst        (rst),
    .oe         (oe),
    .command_in (command_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .d_out      (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  // A released bus reads as Z in a 4-state simulator and as 0 in a 2-state one;
  // either way no driven 1 may appear.
  function automatic logic [15:0] bus_released(input logic [15:0] v);
    return {15'd0, (v === 16'hzzzz) || (v === 16'h0000)};
  endfunction

  task automatic run_op(input string tag, input logic [3:0] cmd, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp);
    @(negedge clk);
    command_in = cmd;
    a_in       = a;
    b_in       = b;
    @(posedge clk);
    #1;
    check(tag, d_out, exp);
  endtask

  logic [15:0] sweep_exp [16];
  string       sweep_name [16];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    sweep_exp  = '{16'd336, 16'd136, 16'd65470, 16'd134, 16'd27135, 16'd0, 16'd270, 16'd67,
                   16'd129, 16'd207, 16'd78, 16'd120, 16'd126, 16'd48, 16'd177, 16'd135};
    sweep_name = '{"add", "inc", "sub", "dec", "mul", "div", "shl", "shr",
                   "and", "or", "xor", "not", "nand", "nor", "xnor", "buf"};

    rst        = 1'b1;
    oe         = 1'b1;
    command_in = 4'd0;
    a_in       = 8'd0;
    b_in       = 8'd0;
    #1;
    check("reset_immediate", d_out, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_held", d_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("sweep_%s", sweep_name[i]), 4'(i), 8'd135, 8'd201, sweep_exp[i]);
    end

    run_op("div_by_zero", 4'd5, 8'd77,  8'd0,   16'hFFFF);
    run_op("dec_zero",    4'd3, 8'd0,   8'd9,   16'hFFFF);
    run_op("mul_max",     4'd4, 8'd255, 8'd255, 16'd65025);
    run_op("shl_max",     4'd6, 8'd255, 8'd0,   16'd510);
    run_op("div_exact",   4'd5, 8'd200, 8'd7,   16'd28);
    run_op("add_max",     4'd0, 8'd255, 8'd255, 16'd510);

    // Operand changes between edges must not disturb the held result.
    #2;
    command_in = 4'd11;
    a_in       = 8'h0F;
    #1;
    check("hold_between_edges", d_out, 16'd510);

    // Bus released while the register keeps capturing.
    @(negedge clk);
    oe         = 1'b0;
    command_in = 4'd3;
    a_in       = 8'd0;
    #1;
    check("oe_off_immediate", bus_released(d_out), 16'd1);
    @(posedge clk);
    #1;
    check("oe_off_after_edge", bus_released(d_out), 16'd1);
    @(negedge clk);
    command_in = 4'd9;
    a_in       = 8'h0C;
    b_in       = 8'h30;
    @(posedge clk);
    #2;
    oe = 1'b1;
    #1;
    check("oe_on_midcycle", d_out, 16'h003C);

    // Async reset between edges clears the bus at once and drops the pending result.
    @(negedge clk);
    command_in = 4'd0;
    a_in       = 8'd100;
    b_in       = 8'd50;
    @(posedge clk);
    #1;
    check("pre_reset", d_out, 16'd150);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_midcycle", d_out, 16'h0000);
    @(posedge clk);
    #1;
    check("async_reset_held", d_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_release_no_edge", d_out, 16'h0000);
    @(posedge clk);
    #1;
    check("first_capture_after_reset", d_out, 16'd150);

    run_op("xnor_mixed", 4'd14, 8'hA5, 8'h0F, 16'h0055);
    run_op("sub_no_wrap", 4'd2, 8'd201, 8'd135, 16'd66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
